// File: rtl/bcd_stopwatch_pkg.sv
// rtl/bcd_stopwatch_pkg.sv - shared types and constants for the BCD stopwatch
package bcd_stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam int         DEFAULT_PRESCALE = 100;
    localparam logic [3:0] BCD_MAX          = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one up/down BCD digit with step enable, carry/borrow out and sync clear
module bcd_digit
    import bcd_stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       step_i,
    input  logic       up_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic       at_limit;

    // At 9 going up or 0 going down, this step rolls over and ripples onward.
    assign at_limit = up_i ? (digit_q == BCD_MAX) : (digit_q == 4'd0);
    assign carry_o  = step_i & at_limit;

    always_comb begin
        digit_d = digit_q;
        if (clear_i) begin
            digit_d = 4'd0;
        end else if (step_i) begin
            if (at_limit) begin
                digit_d = up_i ? 4'd0 : BCD_MAX;
            end else begin
                digit_d = up_i ? (digit_q + 4'd1) : (digit_q - 4'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - four-digit BCD up/down stopwatch with IDLE/RUN/PAUSE control
module bcd_stopwatch
    import bcd_stopwatch_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1k,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        up_down,
    output logic [15:0] digits,
    output logic        running,
    output logic        wrap
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    sw_state_t     state_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          running_q;
    logic          wrap_q;

    logic tick_run;
    logic step;
    logic carry0, carry1, carry2, carry3;

    // Counting looks at the pre-edge state, so a tick alongside a pause still lands.
    assign tick_run = (state_q == ST_RUN) && tick_1k;
    assign step     = tick_run && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (tick_run) begin
            presc_d = step ? '0 : (presc_q + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else if (clear) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= carry3;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_stop) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (start_stop) begin
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    bcd_digit u_digit0 (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .step_i  (step),
        .up_i    (up_down),
        .digit_o (digits[3:0]),
        .carry_o (carry0)
    );

    bcd_digit u_digit1 (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .step_i  (carry0),
        .up_i    (up_down),
        .digit_o (digits[7:4]),
        .carry_o (carry1)
    );

    bcd_digit u_digit2 (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .step_i  (carry1),
        .up_i    (up_down),
        .digit_o (digits[11:8]),
        .carry_o (carry2)
    );

    bcd_digit u_digit3 (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .step_i  (carry2),
        .up_i    (up_down),
        .digit_o (digits[15:12]),
        .carry_o (carry3)
    );

    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb/tb_bcd_stopwatch.sv - self-checking bench for bcd_stopwatch at PRESCALE 100 and 1
module tb_bcd_stopwatch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_1k = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        up_down = 1'b1;
    logic [15:0] dig_a, dig_b;
    logic        run_a, run_b, wrap_a, wrap_b;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    bcd_stopwatch #(.PRESCALE(100)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .tick_1k    (tick_1k),
        .start_stop (start_stop),
        .clear      (clear),
        .up_down    (up_down),
        .digits     (dig_a),
        .running    (run_a),
        .wrap       (wrap_a)
    );

    bcd_stopwatch #(.PRESCALE(1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .tick_1k    (tick_1k),
        .start_stop (start_stop),
        .clear      (clear),
        .up_down    (up_down),
        .digits     (dig_b),
        .running    (run_b),
        .wrap       (wrap_b)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    int ps_val [2] = '{100, 1};
    int m_state [2] = '{0, 0};
    int m_cnt [2] = '{0, 0};
    int m_pre [2] = '{0, 0};
    bit m_wrap [2] = '{1'b0, 1'b0};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: counter kept as a plain integer 0..9999, state as a small integer.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || clear) begin
                m_state[i] = M_IDLE;
                m_cnt[i]   = 0;
                m_pre[i]   = 0;
                m_wrap[i]  = 1'b0;
            end else begin
                m_wrap[i] = 1'b0;
                if (m_state[i] == M_RUN && tick_1k) begin
                    if (m_pre[i] == ps_val[i] - 1) begin
                        m_pre[i] = 0;
                        if (up_down) begin
                            m_cnt[i] = m_cnt[i] + 1;
                            if (m_cnt[i] == 10000) begin
                                m_cnt[i]  = 0;
                                m_wrap[i] = 1'b1;
                            end
                        end else if (m_cnt[i] == 0) begin
                            m_cnt[i]  = 9999;
                            m_wrap[i] = 1'b1;
                        end else begin
                            m_cnt[i] = m_cnt[i] - 1;
                        end
                    end else begin
                        m_pre[i] = m_pre[i] + 1;
                    end
                end
                if (start_stop) begin
                    m_state[i] = (m_state[i] == M_RUN) ? M_PAUSE : M_RUN;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_digits", {16'd0, dig_a}, {16'd0, to_bcd(m_cnt[0])});
            chk("a_running", {31'd0, run_a}, {31'd0, m_state[0] == M_RUN});
            chk("a_wrap", {31'd0, wrap_a}, {31'd0, m_wrap[0]});
            chk("b_digits", {16'd0, dig_b}, {16'd0, to_bcd(m_cnt[1])});
            chk("b_running", {31'd0, run_b}, {31'd0, m_state[1] == M_RUN});
            chk("b_wrap", {31'd0, wrap_b}, {31'd0, m_wrap[1]});
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cycle();
        start_stop = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_1k = 1'b1;
            cycle();
            tick_1k = 1'b0;
            cycle();
        end
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        chk("rst_a_digits", {16'd0, dig_a}, 32'h0);
        chk("rst_a_running", {31'd0, run_a}, 32'h0);
        chk("rst_b_wrap", {31'd0, wrap_b}, 32'h0);

        // Ticks before any start_stop are ignored.
        ticks(5);
        chk("idle_ticks_b", {16'd0, dig_b}, 32'h0);

        // Scenario 1: 1000 ticks up.
        up_down = 1'b1;
        pulse_ss();
        ticks(1000);
        chk("s1_a_digits", {16'd0, dig_a}, 32'h0010);
        chk("s1_a_running", {31'd0, run_a}, 32'h1);
        chk("s1_b_digits", {16'd0, dig_b}, 32'h1000);

        // Scenario 2: wrap both directions on PRESCALE=1.
        do_reset();
        up_down = 1'b0;
        pulse_ss();
        tick_1k = 1'b1;
        cycle();
        tick_1k = 1'b0;
        chk("s2_down_digits", {16'd0, dig_b}, 32'h9999);
        chk("s2_down_wrap", {31'd0, wrap_b}, 32'h1);
        cycle();
        chk("s2_wrap_one_cycle", {31'd0, wrap_b}, 32'h0);
        up_down = 1'b1;
        tick_1k = 1'b1;
        cycle();
        tick_1k = 1'b0;
        chk("s2_up_digits", {16'd0, dig_b}, 32'h0000);
        chk("s2_up_wrap", {31'd0, wrap_b}, 32'h1);
        cycle();

        // Scenario 3: pause holds prescaler and digits.
        do_reset();
        pulse_ss();
        ticks(150);
        pulse_ss();
        ticks(500);
        chk("s3_hold_digits", {16'd0, dig_a}, 32'h0001);
        chk("s3_paused", {31'd0, run_a}, 32'h0);
        pulse_ss();
        ticks(50);
        chk("s3_resume_digits", {16'd0, dig_a}, 32'h0002);

        // Scenario 4: clear beats start_stop in the same cycle.
        do_reset();
        pulse_ss();
        ticks(120);
        clear = 1'b1;
        start_stop = 1'b1;
        cycle();
        clear = 1'b0;
        start_stop = 1'b0;
        chk("s4_digits", {16'd0, dig_a}, 32'h0);
        chk("s4_running", {31'd0, run_a}, 32'h0);
        ticks(200);
        chk("s4_ignored_a", {16'd0, dig_a}, 32'h0);
        chk("s4_ignored_b", {16'd0, dig_b}, 32'h0);

        // Scenario 5: reset between clock edges takes effect immediately.
        pulse_ss();
        ticks(250);
        chk("s5_pre_a", {16'd0, dig_a}, 32'h0002);
        #2;
        reset = 1'b1;
        #1;
        chk("s5_async_a_digits", {16'd0, dig_a}, 32'h0);
        chk("s5_async_b_digits", {16'd0, dig_b}, 32'h0);
        chk("s5_async_running", {30'd0, run_a, run_b}, 32'h0);
        cycle();
        reset = 1'b0;

        // Scenario 6: tick and start_stop together still count, then pause.
        pulse_ss();
        ticks(1);
        chk("s6_before", {16'd0, dig_b}, 32'h0001);
        tick_1k = 1'b1;
        start_stop = 1'b1;
        cycle();
        tick_1k = 1'b0;
        start_stop = 1'b0;
        chk("s6_digits", {16'd0, dig_b}, 32'h0002);
        chk("s6_paused", {31'd0, run_b}, 32'h0);
        ticks(3);
        chk("s6_hold", {16'd0, dig_b}, 32'h0002);

        cycle();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 Parameter PRESCALE, default 100: number of tick_1k pulses per count step (100 gives 0.1 s resolution); legal range 1..1023.
REQ-002 clk  input  1  single system clock (50 MHz); all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tick_1k  input  1  one-clk-wide enable pulse at 1 kHz from the upstream divider stage.
REQ-005 start_stop  input  1  one-clk-wide command pulse: start or pause toggle.
REQ-006 clear  input  1  one-clk-wide command pulse: stop and zero.
REQ-007 up_down  input  1  count direction: 1 = up, 0 = down.
REQ-008 digits  output  16  four packed BCD digits; [3:0] is least significant.
REQ-009 running  output  1  high while the state is RUN.
REQ-010 wrap  output  1  one-clk pulse on a count step that wraps 9999->0000 (up) or 0000->9999 (down).

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, RUN and PAUSE.
REQ-012 Transitions: IDLE--start_stop-->RUN; RUN--start_stop-->PAUSE; PAUSE--start_stop-->RUN; any state--clear-->IDLE.
REQ-013 When clear and start_stop are asserted in the same cycle, clear SHALL win, giving IDLE with zeroed digits.
REQ-014 Entering IDLE by clear SHALL set digits to 0x0000, the prescaler to 0 and wrap to 0 on the same edge.
REQ-015 The prescaler SHALL count tick_1k pulses only while the current state is RUN; ticks in IDLE or PAUSE SHALL be ignored.
REQ-016 In PAUSE, the prescaler and digits SHALL hold, and resuming SHALL continue from the held prescaler value.
REQ-017 When a tick arrives with prescaler == PRESCALE-1, the prescaler SHALL return to 0 and a count step SHALL occur, updating digits on that same edge (zero added latency).
REQ-018 A tick arriving in the same cycle as start_stop while in RUN SHALL still be counted, because counting uses the pre-edge state.
REQ-019 A count step SHALL use the value of up_down sampled on the step cycle.
REQ-020 Each digit SHALL stay within 0..9.
REQ-021 Up step: a digit at 9 becomes 0 and carries into the next digit.
REQ-022 Down step: a digit at 0 becomes 9 and borrows from the next digit.
REQ-023 Wrap-around: 9999 up gives 0000 and 0000 down gives 9999; wrap SHALL be high for exactly that one cycle.
REQ-024 wrap SHALL be 0 on every cycle without a wrapping step.
REQ-025 running SHALL be registered and equal (state == RUN).
REQ-026 Inputs are synchronous to clk; command pulses longer than one cycle SHALL act once per asserted cycle, with no internal edge detection.

Reset
REQ-027 While reset is high, the block SHALL immediately enter IDLE with digits = 0x0000, prescaler = 0, running = 0 and wrap = 0, regardless of operation in progress.
REQ-028 After reset deasserts, the block SHALL ignore ticks until the first start_stop pulse.

Structure
REQ-029 A shared package SHALL hold the FSM state type (IDLE/RUN/PAUSE), the default PRESCALE value and the BCD digit maximum constant (9).
REQ-030 One sub-module, bcd_digit, SHALL be provided and instantiated four times in a carry/borrow chain.
REQ-031 bcd_digit SHALL be a single up/down BCD digit with step-enable input, direction input, carry/borrow-out and synchronous clear.
REQ-032 The prescaler SHALL be ceil(log2(PRESCALE)) bits wide, minimum 1 bit.

Verification
REQ-033 Scenario 1: PRESCALE=100, reset, start_stop, 1000 ticks up -> digits=0x0010 and running=1.
REQ-034 Scenario 2: PRESCALE=1, digits at 0x9999 with up step -> digits=0x0000 and a one-cycle wrap pulse; same setup at 0x0000 with down step -> digits=0x9999 and wrap.
REQ-035 Scenario 3: PRESCALE=100, run 150 ticks, start_stop, 500 ticks -> digits hold 0x0001; then start_stop and 50 ticks -> digits=0x0002.
REQ-036 Scenario 4: clear and start_stop in the same cycle during RUN -> IDLE, digits=0x0000, running=0; later ticks are ignored.
REQ-037 Scenario 5: reset asserted mid-RUN between clock edges -> outputs zero immediately, without waiting for a clock edge.
REQ-038 Scenario 6: PRESCALE=1, RUN, tick and start_stop in the same cycle -> digits increment by 1 and state becomes PAUSE.
